// File: rtl/vx_tcache_pkg.sv
// Shared definitions for the texture-cache lane server: default sizes,
// state encoding and the lane-index type.
package vx_tcache_pkg;

    localparam int unsigned TC_NUM_REQS   = 4;
    localparam int unsigned TC_WORD_SIZE  = 4;
    localparam int unsigned TC_ADDR_WIDTH = 30;
    localparam int unsigned TC_TAG_WIDTH  = 8;

    localparam int unsigned LANE_BITS = (TC_NUM_REQS > 1) ? $clog2(TC_NUM_REQS) : 1;

    typedef logic [LANE_BITS-1:0] lane_t;

    // Server state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RSP   = 2'd3;

endpackage

// File: rtl/vx_tcache_lane_server_if.sv
// Request/response bus between the texture unit, the lane server and the
// word memory behind it. The server takes the slave view.
interface vx_tcache_lane_server_if
    import vx_tcache_pkg::*;
#(
    parameter int unsigned NUM_REQS   = TC_NUM_REQS,
    parameter int unsigned WORD_SIZE  = TC_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = TC_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH  = TC_TAG_WIDTH
);
    localparam int unsigned LANE_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [NUM_REQS-1:0]             req_valid;
    logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr;
    logic [TAG_WIDTH-1:0]            req_tag;
    logic                            req_ready;
    logic                            rsp_valid;
    logic [NUM_REQS-1:0]             rsp_tmask;
    logic [NUM_REQS*WORD_SIZE*8-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]            rsp_tag;
    logic                            rsp_ready;
    logic                            mem_req_valid;
    logic [ADDR_WIDTH-1:0]           mem_req_addr;
    logic [LANE_W-1:0]               mem_req_lane;
    logic                            mem_req_ready;
    logic                            mem_rsp_valid;
    logic [WORD_SIZE*8-1:0]          mem_rsp_data;
    logic [LANE_W-1:0]               mem_rsp_lane;

    modport slave (
        input  req_valid, req_addr, req_tag, rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_lane,
        output req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag,
        output mem_req_valid, mem_req_addr, mem_req_lane
    );

    modport master (
        output req_valid, req_addr, req_tag, rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_lane,
        input  req_ready, rsp_valid, rsp_tmask, rsp_data, rsp_tag,
        input  mem_req_valid, mem_req_addr, mem_req_lane
    );

endinterface

// File: rtl/vx_tcache_lane_coalescer.sv
// Combinational address coalescer: each lane points at the lowest valid lane
// sharing its address; only lanes that point at themselves need a memory read.
module vx_tcache_lane_coalescer #(
    parameter int unsigned NUM_REQS   = 4,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned LANE_W     = 2
) (
    input  logic [NUM_REQS-1:0]            mask,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] addrs,
    output logic [NUM_REQS*LANE_W-1:0]     leader,
    output logic [NUM_REQS-1:0]            leader_mask
);

    logic found;

    // Leader search: first match from lane 0 upward wins.
    always_comb begin
        leader      = '0;
        leader_mask = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            found = 1'b0;
            for (int j = 0; j < NUM_REQS; j++) begin
                if (j <= i && !found && mask[j] &&
                    addrs[j*ADDR_WIDTH +: ADDR_WIDTH] == addrs[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    found = 1'b1;
                    leader[i*LANE_W +: LANE_W] = LANE_W'(j);
                end
            end
            leader_mask[i] = mask[i] && (leader[i*LANE_W +: LANE_W] == LANE_W'(i));
        end
    end

endmodule

// File: rtl/vx_tcache_lane_server.sv
// Texture-cache responder: accepts one multi-lane read, issues one memory
// read per unique address, gathers words in any order and returns them with
// the original tag.
module vx_tcache_lane_server
    import vx_tcache_pkg::*;
#(
    parameter int unsigned NUM_REQS   = TC_NUM_REQS,
    parameter int unsigned WORD_SIZE  = TC_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = TC_ADDR_WIDTH,
    parameter int unsigned TAG_WIDTH  = TC_TAG_WIDTH
) (
    input logic              clk,
    input logic              reset,
    vx_tcache_lane_server_if.slave bus
);

    localparam int unsigned LANE_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned WORD_W = WORD_SIZE * 8;

    state_t                         state_q, state_d;
    logic [NUM_REQS-1:0]            mask_q, mask_d;
    logic [NUM_REQS-1:0]            issue_q, issue_d;  // leaders not yet sent to memory
    logic [NUM_REQS-1:0]            pend_q, pend_d;    // leaders whose word has not returned
    logic [NUM_REQS*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_REQS*LANE_W-1:0]     leader_q, leader_d, leader_c;
    logic [NUM_REQS-1:0]            leader_mask_c;
    logic [TAG_WIDTH-1:0]           tag_q, tag_d;
    logic [NUM_REQS*WORD_W-1:0]     data_q, data_d;
    logic [NUM_REQS-1:0]            in_flight;
    logic [LANE_W-1:0]              issue_lane;
    logic                           issue_fire;
    logic                           capture;
    logic                           spurious;

    vx_tcache_lane_coalescer #(
        .NUM_REQS   (NUM_REQS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANE_W     (LANE_W)
    ) u_coalescer (
        .mask        (bus.req_valid),
        .addrs       (bus.req_addr),
        .leader      (leader_c),
        .leader_mask (leader_mask_c)
    );

    // Lowest leader lane still waiting to be issued.
    always_comb begin
        issue_lane = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (issue_q[i]) issue_lane = LANE_W'(i);
        end
    end

    // Only reads that were issued and not yet answered may be captured.
    assign in_flight  = pend_q & ~issue_q;
    assign capture    = bus.mem_rsp_valid && (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                        in_flight[bus.mem_rsp_lane];
    assign spurious   = bus.mem_rsp_valid && !capture;
    assign issue_fire = bus.mem_req_valid && bus.mem_req_ready;

    assign bus.req_ready     = (state_q == ST_IDLE) && !reset;
    assign bus.mem_req_valid = (state_q == ST_ISSUE) && (|issue_q);
    assign bus.mem_req_addr  = addr_q[issue_lane*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.mem_req_lane  = issue_lane;
    assign bus.rsp_valid     = (state_q == ST_RSP);
    assign bus.rsp_tmask     = mask_q;
    assign bus.rsp_data      = data_q;
    assign bus.rsp_tag       = tag_q;

    // Next-state: accept, issue, gather and respond.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        issue_d  = issue_q;
        pend_d   = pend_q;
        addr_d   = addr_q;
        leader_d = leader_q;
        tag_d    = tag_q;
        data_d   = data_q;

        // A returned word fans out to the leader and all of its followers.
        if (capture) begin
            pend_d[bus.mem_rsp_lane] = 1'b0;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (mask_q[i] && leader_q[i*LANE_W +: LANE_W] == bus.mem_rsp_lane) begin
                    data_d[i*WORD_W +: WORD_W] = bus.mem_rsp_data;
                end
            end
        end
        if (issue_fire) issue_d[issue_lane] = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    mask_d   = bus.req_valid;
                    addr_d   = bus.req_addr;
                    tag_d    = bus.req_tag;
                    leader_d = leader_c;
                    issue_d  = leader_mask_c;
                    pend_d   = leader_mask_c;
                    data_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_d == '0) state_d = (pend_d == '0) ? ST_RSP : ST_WAIT;
            end
            ST_WAIT: begin
                if (pend_d == '0) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any request in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            issue_q  <= '0;
            pend_q   <= '0;
            addr_q   <= '0;
            leader_q <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            issue_q  <= issue_d;
            pend_q   <= pend_d;
            addr_q   <= addr_d;
            leader_q <= leader_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

    // Words for lanes with no read in flight are dropped; flag them in simulation.
    assert property (@(posedge clk) disable iff (reset) !spurious)
        else $warning("vx_tcache_lane_server: dropped memory response for lane %0d",
                      bus.mem_rsp_lane);

endmodule

// File: tb/tb_vx_tcache_lane_server.sv
// Directed bench for vx_tcache_lane_server: stimulus queues expected
// responses, a monitor pops and compares them on each response handshake.
module tb_vx_tcache_lane_server;
    import vx_tcache_pkg::*;

    typedef struct packed {
        logic [3:0]   tmask;
        logic [127:0] data;
        logic [7:0]   tag;
    } rsp_t;

    typedef struct packed {
        lane_t       lane;
        logic [29:0] addr;
    } iss_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_hs     = 0;
    int   n_sent   = 0;
    rsp_t exp_q[$];
    iss_t iss_log[$];

    vx_tcache_lane_server_if bus ();

    vx_tcache_lane_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response handshake is matched against the queue head.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            n_hs++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got tag %0h expected no response", bus.rsp_tag);
            end else begin
                e = exp_q.pop_front();
                check("rsp_tmask", 128'(bus.rsp_tmask), 128'(e.tmask));
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_tag", 128'(bus.rsp_tag), 128'(e.tag));
            end
        end
    end

    // Log each memory read at the edge where it is accepted.
    always @(negedge clk) begin
        if (!reset && bus.mem_req_valid && bus.mem_req_ready)
            iss_log.push_back('{lane: bus.mem_req_lane, addr: bus.mem_req_addr});
    end

    task automatic send(input logic [3:0] m, input logic [29:0] a0, input logic [29:0] a1,
                        input logic [29:0] a2, input logic [29:0] a3, input logic [7:0] t,
                        input logic [127:0] ed, input bit expect_rsp);
        int g = 0;
        while (!bus.req_ready && g < 50) begin tick(); g++; end
        check("req_ready_before_send", 128'(bus.req_ready), 128'(1));
        bus.req_valid = m;
        bus.req_addr  = {a3, a2, a1, a0};
        bus.req_tag   = t;
        if (expect_rsp) begin
            exp_q.push_back('{tmask: m, data: ed, tag: t});
            n_sent++;
        end
        tick();
        bus.req_valid = '0;
    endtask

    task automatic wait_issue(input lane_t lane, input logic [29:0] addr);
        iss_t s;
        int g = 0;
        while (iss_log.size() == 0 && g < 50) begin tick(); g++; end
        if (iss_log.size() == 0) begin
            n_checks++;
            $display("FAIL issue_timeout: got no mem_req expected lane %0d", lane);
        end else begin
            s = iss_log.pop_front();
            check("mem_req_lane", 128'(s.lane), 128'(lane));
            check("mem_req_addr", 128'(s.addr), 128'(addr));
        end
    endtask

    task automatic mem_rsp(input lane_t lane, input logic [31:0] d);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_lane  = lane;
        bus.mem_rsp_data  = d;
        tick();
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 50) begin tick(); g++; end
        check("rsp_drained", 128'(exp_q.size()), 128'(0));
        tick();
    endtask

    initial begin
        bus.req_valid     = '0;
        bus.req_addr      = '0;
        bus.req_tag       = '0;
        bus.rsp_ready     = 1'b1;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_lane  = '0;

        // Reset values
        #1;
        check("reset_req_ready", 128'(bus.req_ready), 128'(0));
        check("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("reset_mem_req_valid", 128'(bus.mem_req_valid), 128'(0));
        check("reset_rsp_data", bus.rsp_data, 128'(0));
        check("reset_rsp_tmask_tag", 128'({bus.rsp_tmask, bus.rsp_tag}), 128'(0));
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("idle_req_ready", 128'(bus.req_ready), 128'(1));

        // Single lane, memory latency 1: rsp_valid three cycles after accept
        send(4'b0001, 30'h10, 30'h0, 30'h0, 30'h0, 8'h5A, {96'h0, 32'hDEADBEEF}, 1'b1);
        check("t1_rsp_c1", 128'(bus.rsp_valid), 128'(0));
        wait_issue(2'd0, 30'h10);
        check("t1_rsp_c2", 128'(bus.rsp_valid), 128'(0));
        mem_rsp(2'd0, 32'hDEADBEEF);
        check("t1_rsp_c3", 128'(bus.rsp_valid), 128'(1));
        drain();

        // Four distinct addresses, reverse-order returns
        send(4'b1111, 30'h100, 30'h101, 30'h102, 30'h103, 8'h11,
             {32'h104, 32'h103, 32'h102, 32'h101}, 1'b1);
        for (int i = 0; i < 4; i++) wait_issue(lane_t'(i), 30'h100 + 30'(i));
        mem_rsp(2'd3, 32'h104);
        mem_rsp(2'd2, 32'h103);
        mem_rsp(2'd1, 32'h102);
        check("t2_rsp_before_last", 128'(bus.rsp_valid), 128'(0));
        mem_rsp(2'd0, 32'h101);
        check("t2_rsp_after_last", 128'(bus.rsp_valid), 128'(1));
        tick();
        check("t2_rsp_once", 128'(bus.rsp_valid), 128'(0));
        drain();

        // Coalescing: two unique addresses across four lanes
        send(4'b1111, 30'h20, 30'h30, 30'h20, 30'h30, 8'h22,
             {32'hB, 32'hA, 32'hB, 32'hA}, 1'b1);
        wait_issue(2'd0, 30'h20);
        wait_issue(2'd1, 30'h30);
        mem_rsp(2'd0, 32'hA);
        mem_rsp(2'd1, 32'hB);
        drain();
        check("t3_two_issues_only", 128'(iss_log.size()), 128'(0));

        // Backpressure on memory issue and on response
        send(4'b0011, 30'h40, 30'h44, 30'h0, 30'h0, 8'h33,
             {64'h0, 32'h4444, 32'h4040}, 1'b1);
        wait_issue(2'd0, 30'h40);
        bus.mem_req_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", 128'(bus.mem_req_valid), 128'(1));
            check("t4_stall_lane_addr", 128'({bus.mem_req_lane, bus.mem_req_addr}),
                  128'({2'd1, 30'h44}));
            check("t4_stall_req_ready", 128'(bus.req_ready), 128'(0));
            tick();
        end
        bus.mem_req_ready = 1'b1;
        wait_issue(2'd1, 30'h44);
        bus.rsp_ready = 1'b0;
        mem_rsp(2'd0, 32'h4040);
        mem_rsp(2'd1, 32'h4444);
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid", 128'(bus.rsp_valid), 128'(1));
            check("t4_hold_data", bus.rsp_data, {64'h0, 32'h4444, 32'h4040});
            check("t4_hold_tag", 128'(bus.rsp_tag), 128'(8'h33));
            check("t4_hold_req_ready", 128'(bus.req_ready), 128'(0));
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        check("t4_req_ready_after", 128'(bus.req_ready), 128'(1));
        drain();
        check("t4_no_dup_issue", 128'(iss_log.size()), 128'(0));

        // Sparse mask with a stray response for an unmasked lane
        send(4'b0101, 30'h50, 30'h50, 30'h60, 30'h60, 8'h44,
             {32'h0, 32'h2222, 32'h0, 32'h1111}, 1'b1);
        wait_issue(2'd0, 30'h50);
        wait_issue(2'd2, 30'h60);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_lane  = 2'd1;
        bus.mem_rsp_data  = 32'hBAD;
        #1;
        check("t5_spurious_flag", 128'(dut.spurious), 128'(1));
        tick();
        bus.mem_rsp_valid = 1'b0;
        check("t5_no_rsp", 128'(bus.rsp_valid), 128'(0));
        mem_rsp(2'd0, 32'h1111);
        mem_rsp(2'd2, 32'h2222);
        drain();

        // Reset while two reads are outstanding
        send(4'b0011, 30'h70, 30'h74, 30'h0, 30'h0, 8'h66, 128'h0, 1'b0);
        wait_issue(2'd0, 30'h70);
        wait_issue(2'd1, 30'h74);
        reset = 1'b1;
        #1;
        check("t6_rst_req_ready", 128'(bus.req_ready), 128'(0));
        check("t6_rst_mem_req", 128'(bus.mem_req_valid), 128'(0));
        check("t6_rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("t6_rst_rsp_fields", bus.rsp_data | 128'({bus.rsp_tmask, bus.rsp_tag}), 128'(0));
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t6_req_ready_release", 128'(bus.req_ready), 128'(1));
        mem_rsp(2'd0, 32'hDEAD0000);
        mem_rsp(2'd1, 32'hDEAD0001);
        check("t6_late_ignored", 128'({bus.rsp_valid, bus.mem_req_valid}), 128'(0));
        check("t6_late_data", bus.rsp_data, 128'(0));
        send(4'b0010, 30'h0, 30'h80, 30'h0, 30'h0, 8'h77, {64'h0, 32'h8080, 32'h0}, 1'b1);
        wait_issue(2'd1, 30'h80);
        mem_rsp(2'd1, 32'h8080);
        drain();

        check("rsp_handshakes", 128'(n_hs), 128'(n_sent));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
